axis_pkt_store_fwd: RTL and testbench

AXIS_PKT_STORE_FWD -- requirements
Module: axis_pkt_store_fwd

---
 rtl/axis_pkg.sv | 13 +
 rtl/axis_sdp_ram.sv | 27 ++
 rtl/axis_pkt_store_fwd.sv | 170 +++++++++++++++++
 tb/tb_axis_pkt_store_fwd.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared types and default widths for the AXI-Stream packet store-and-forward buffer.
package axis_pkg;

    localparam int DEF_DATA_WIDTH = 512;
    localparam int DEF_KEEP_WIDTH = 64;
    localparam int DEF_USER_WIDTH = 1;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_DROP = 1'b1
    } in_state_e;

endpackage

// File: rtl/axis_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output that
// holds its value while rd_en_i is low.
module axis_sdp_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [WIDTH-1:0]         rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/axis_pkt_store_fwd.sv
// Store-and-forward packet buffer: packets become visible downstream only once fully
// received without error; errored or overflowing packets are rewound and counted.
module axis_pkt_store_fwd
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int KEEP_WIDTH = DEF_KEEP_WIDTH,
    parameter int USER_WIDTH = DEF_USER_WIDTH,
    parameter int DEPTH      = 64
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic [USER_WIDTH-1:0]    s_axis_tuser,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
    output logic [USER_WIDTH-1:0]    m_axis_tuser,
    output logic [31:0]              pkt_fwd_count,
    output logic [31:0]              pkt_drop_count,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int RW = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;
    localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    in_state_e      state_q;
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  commit_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [31:0]    fwd_cnt_q;
    logic [31:0]    drop_cnt_q;

    logic           s_acc;
    logic           ovf;
    logic           wr_en;
    logic [RW-1:0]  wr_word;

    assign s_axis_tready = RST_N;
    assign s_acc         = s_axis_tvalid && s_axis_tready;
    assign ovf           = (wr_ptr_q - rd_ptr_q) == FULL_LVL;
    assign wr_en         = s_acc && (state_q == ST_FILL) && !ovf;
    assign wr_word       = {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};

    // Input side: speculative write pointer, commit on a clean tlast, rewind otherwise.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_FILL;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            drop_cnt_q   <= '0;
        end else if (s_acc) begin
            case (state_q)
                ST_FILL: begin
                    if (ovf) begin
                        wr_ptr_q <= commit_ptr_q;
                        if (s_axis_tlast) begin
                            drop_cnt_q <= sat_inc(drop_cnt_q);
                        end else begin
                            state_q <= ST_DROP;
                        end
                    end else if (s_axis_tlast && s_axis_tuser[0]) begin
                        wr_ptr_q   <= commit_ptr_q;
                        drop_cnt_q <= sat_inc(drop_cnt_q);
                    end else begin
                        wr_ptr_q <= wr_ptr_q + PW'(1);
                        if (s_axis_tlast) begin
                            commit_ptr_q <= wr_ptr_q + PW'(1);
                        end
                    end
                end
                ST_DROP: begin
                    if (s_axis_tlast) begin
                        drop_cnt_q <= sat_inc(drop_cnt_q);
                        state_q    <= ST_FILL;
                    end
                end
                default: state_q <= ST_FILL;
            endcase
        end
    end

    logic           vld_p1_q;
    logic [RW-1:0]  rdata_p1;
    logic           vld_p2_q;
    logic [RW-1:0]  data_p2_q;
    logic           sk_vld_q;
    logic [RW-1:0]  sk_data_q;
    logic           rd_en;
    logic           p1_move;
    logic           m_pop;

    axis_sdp_ram #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i     (CLK),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q[AW-1:0]),
        .wr_data_i (wr_word),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q[AW-1:0]),
        .rd_data_o (rdata_p1)
    );

    // The read decision uses registered state only; the skid slot absorbs the beat
    // already in flight from the RAM when downstream stalls.
    assign m_pop   = vld_p2_q && m_axis_tready;
    assign p1_move = vld_p1_q && !sk_vld_q;
    assign rd_en   = (commit_ptr_q != rd_ptr_q) && (!vld_p1_q || p1_move);

    // Stage p1 -> p2: RAM output into the output register, or into the skid slot.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_ptr_q  <= '0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            data_p2_q <= '0;
            sk_vld_q  <= 1'b0;
            sk_data_q <= '0;
            fwd_cnt_q <= '0;
        end else begin
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
                vld_p1_q <= 1'b1;
            end else if (p1_move) begin
                vld_p1_q <= 1'b0;
            end

            if (!vld_p2_q || m_pop) begin
                if (sk_vld_q) begin
                    data_p2_q <= sk_data_q;
                    vld_p2_q  <= 1'b1;
                    sk_vld_q  <= 1'b0;
                end else if (p1_move) begin
                    data_p2_q <= rdata_p1;
                    vld_p2_q  <= 1'b1;
                end else begin
                    vld_p2_q  <= 1'b0;
                end
            end else if (p1_move) begin
                sk_data_q <= rdata_p1;
                sk_vld_q  <= 1'b1;
            end

            if (m_pop && data_p2_q[0]) begin
                fwd_cnt_q <= sat_inc(fwd_cnt_q);
            end
        end
    end

    assign m_axis_tvalid = vld_p2_q;
    assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = data_p2_q;
    assign pkt_fwd_count  = fwd_cnt_q;
    assign pkt_drop_count = drop_cnt_q;
    assign occupancy      = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_axis_pkt_store_fwd.sv
// Randomised bench for axis_pkt_store_fwd with a packet-level scoreboard.
module tb_axis_pkt_store_fwd;

    localparam int DW    = 64;
    localparam int KW    = 8;
    localparam int UW    = 1;
    localparam int DEPTH = 64;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic [UW-1:0] s_axis_tuser = '0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [UW-1:0] m_axis_tuser;
    logic [31:0]   pkt_fwd_count;
    logic [31:0]   pkt_drop_count;
    logic [OW-1:0] occupancy;

    axis_pkt_store_fwd #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .USER_WIDTH (UW),
        .DEPTH      (DEPTH)
    ) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tkeep   (s_axis_tkeep),
        .s_axis_tuser   (s_axis_tuser),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tuser   (m_axis_tuser),
        .pkt_fwd_count  (pkt_fwd_count),
        .pkt_drop_count (pkt_drop_count),
        .occupancy      (occupancy)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    obs_cyc[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    bubble_cnt = 0;
    int    unstable_cnt = 0;
    int    exp_fwd = 0;
    int    exp_drop = 0;
    bit    rand_rdy = 1'b0;
    bit    in_pkt = 1'b0;
    bit    stall_prev = 1'b0;
    beat_t prev_b;

    always @(posedge CLK) cyc++;

    // Observe downstream beats mid-cycle; flag bubbles inside a packet and payload
    // changes while stalled.
    always @(negedge CLK) begin : monitor
        beat_t b;
        b = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        if (!RST_N) begin
            in_pkt     = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && (m_axis_tvalid !== 1'b1 || b !== prev_b)) unstable_cnt++;
            if (in_pkt && m_axis_tvalid !== 1'b1) bubble_cnt++;
            if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
                obs_q.push_back(b);
                obs_cyc.push_back(cyc);
                in_pkt = !m_axis_tlast;
            end
            stall_prev = (m_axis_tvalid === 1'b1) && (m_axis_tready !== 1'b1);
            prev_b     = b;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        if (rand_rdy) m_axis_tready = ($urandom_range(0, 9) < 6);
    endtask

    // A packet is forwarded only if error-free and it fits in the free space;
    // every caller starts from a known outstanding level.
    task automatic send_pkt(input int len, input bit err, input bit gaps, input bit expect_fwd);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    s_axis_tvalid = 1'b0;
                    tick();
                end
            end
            b.d = {$urandom, $urandom};
            b.l = (i == len - 1);
            b.k = b.l ? KW'($urandom_range(1, 255)) : '1;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = b.d;
            s_axis_tkeep  = b.k;
            s_axis_tlast  = b.l;
            s_axis_tuser  = UW'(b.l && err);
            tick();
            if (expect_fwd) exp_q.push_back(b);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
        if (expect_fwd) exp_fwd++;
        else exp_drop++;
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        int n;
        n = 0;
        while (obs_q.size() < exp_q.size() && n < budget) begin
            tick();
            n++;
        end
        ok = (obs_q.size() >= exp_q.size());
        repeat (4) tick();
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 000", {s_axis_tready, m_axis_tvalid, m_axis_tlast});
        end
        checks++;
        if (m_axis_tdata !== '0 || m_axis_tkeep !== '0 || m_axis_tuser !== '0) begin
            failures++;
            $display("FAIL reset_payload: got %h/%h/%h want 0", m_axis_tdata, m_axis_tkeep, m_axis_tuser);
        end
        checks++;
        if (pkt_fwd_count !== 0 || pkt_drop_count !== 0 || occupancy !== 0) begin
            failures++;
            $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", pkt_fwd_count, pkt_drop_count, occupancy);
        end
        RST_N = 1'b1;
        #1;
        checks++;
        if (s_axis_tready !== 1'b1) begin
            failures++;
            $display("FAIL tready_after_reset: got %b want 1", s_axis_tready);
        end
        tick();
    endtask

    task automatic test_single_pkt();
        bit ok;
        int base;
        base = exp_q.size();
        m_axis_tready = 1'b1;
        send_pkt(4, 1'b0, 1'b0, 1'b1);
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL latency_c0: tvalid got %b want 0", m_axis_tvalid);
        end
        tick();
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL latency_c1: tvalid got %b want 0", m_axis_tvalid);
        end
        tick();
        checks++;
        if (m_axis_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL latency_c2: tvalid got %b want 1", m_axis_tvalid);
        end
        wait_drain(100, ok);
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL single_beats: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = base; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL single_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
            checks++;
            if (obs_cyc[base + 3] - obs_cyc[base] != 3) begin
                failures++;
                $display("FAIL single_contig: span got %0d want 3", obs_cyc[base + 3] - obs_cyc[base]);
            end
        end
        checks++;
        if (pkt_fwd_count !== 32'(exp_fwd) || pkt_drop_count !== 32'(exp_drop)) begin
            failures++;
            $display("FAIL single_counts: got %0d/%0d want %0d/%0d", pkt_fwd_count, pkt_drop_count, exp_fwd, exp_drop);
        end
    endtask

    task automatic test_err_pkt();
        send_pkt(3, 1'b1, 1'b0, 1'b0);
        repeat (10) tick();
        checks++;
        if (obs_q.size() != exp_q.size() || m_axis_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL err_emitted: beats got %0d want %0d tvalid %b", obs_q.size(), exp_q.size(), m_axis_tvalid);
        end
        checks++;
        if (pkt_drop_count !== 32'(exp_drop) || occupancy !== 0) begin
            failures++;
            $display("FAIL err_drop: drops got %0d want %0d occ %0d want 0", pkt_drop_count, exp_drop, occupancy);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int base;
        m_axis_tready = 1'b0;
        send_pkt(70, 1'b0, 1'b0, (70 <= DEPTH));
        repeat (5) tick();
        checks++;
        if (pkt_drop_count !== 32'(exp_drop) || occupancy !== 0) begin
            failures++;
            $display("FAIL ovf_drop: drops got %0d want %0d occ %0d want 0", pkt_drop_count, exp_drop, occupancy);
        end
        base = exp_q.size();
        send_pkt(8, 1'b0, 1'b0, 1'b1);
        repeat (6) tick();
        checks++;
        if (m_axis_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL ovf_stall_valid: got %b want 1", m_axis_tvalid);
        end
        m_axis_tready = 1'b1;
        wait_drain(200, ok);
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL ovf_beats: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = base; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL ovf_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (pkt_fwd_count !== 32'(exp_fwd) || unstable_cnt != 0) begin
            failures++;
            $display("FAIL ovf_fwd: fwd got %0d want %0d unstable %0d want 0", pkt_fwd_count, exp_fwd, unstable_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int base;
        base = exp_q.size();
        m_axis_tready = 1'b1;
        for (int p = 0; p < 100; p++) send_pkt(2, 1'b0, 1'b0, 1'b1);
        wait_drain(500, ok);
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL b2b_beats: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = base; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL b2b_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
            checks++;
            if (obs_cyc[exp_q.size() - 1] - obs_cyc[base] != 199) begin
                failures++;
                $display("FAIL b2b_contig: span got %0d want 199", obs_cyc[exp_q.size() - 1] - obs_cyc[base]);
            end
        end
        checks++;
        if (pkt_fwd_count !== 32'(exp_fwd) || pkt_drop_count !== 32'(exp_drop)) begin
            failures++;
            $display("FAIL b2b_counts: got %0d/%0d want %0d/%0d", pkt_fwd_count, pkt_drop_count, exp_fwd, exp_drop);
        end
    endtask

    task automatic test_random();
        bit ok;
        int base;
        int len;
        int n;
        bit err;
        base = exp_q.size();
        rand_rdy = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            len = $urandom_range(1, 16);
            err = ($urandom_range(0, 9) == 0);
            n = 0;
            while ((exp_q.size() - obs_q.size()) + len > DEPTH && n < 5000) begin
                tick();
                n++;
            end
            if (n >= 5000) begin
                checks++;
                failures++;
                $display("FAIL rand_pacing: outstanding %0d did not drain", exp_q.size() - obs_q.size());
                break;
            end
            send_pkt(len, err, 1'b1, !err);
        end
        wait_drain(5000, ok);
        rand_rdy = 1'b0;
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rand_beats: got %0d want %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = base; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL rand_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (bubble_cnt != 0 || unstable_cnt != 0) begin
            failures++;
            $display("FAIL rand_flow: bubbles %0d unstable %0d want 0/0", bubble_cnt, unstable_cnt);
        end
        checks++;
        if (pkt_fwd_count !== 32'(exp_fwd) || pkt_drop_count !== 32'(exp_drop)) begin
            failures++;
            $display("FAIL rand_counts: got %0d/%0d want %0d/%0d", pkt_fwd_count, pkt_drop_count, exp_fwd, exp_drop);
        end
    endtask

    task automatic test_reset_midpkt();
        bit ok;
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        send_pkt(3, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = {$urandom, $urandom};
            s_axis_tkeep  = '1;
            s_axis_tlast  = 1'b0;
            tick();
        end
        s_axis_tdata = {$urandom, $urandom};
        #2;
        RST_N = 1'b0;
        #1;
        checks++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast} !== 3'b000 || m_axis_tdata !== '0 || m_axis_tkeep !== '0) begin
            failures++;
            $display("FAIL midrst_outputs: ctrl %b data %h keep %h want 0", {s_axis_tready, m_axis_tvalid, m_axis_tlast}, m_axis_tdata, m_axis_tkeep);
        end
        checks++;
        if (pkt_fwd_count !== 0 || pkt_drop_count !== 0 || occupancy !== 0) begin
            failures++;
            $display("FAIL midrst_counters: got %0d/%0d/%0d want 0/0/0", pkt_fwd_count, pkt_drop_count, occupancy);
        end
        s_axis_tvalid = 1'b0;
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
        exp_fwd = 0;
        exp_drop = 0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        m_axis_tready = 1'b1;
        tick();
        send_pkt(5, 1'b0, 1'b0, 1'b1);
        wait_drain(100, ok);
        checks++;
        if (!ok || obs_q.size() != 5) begin
            failures++;
            $display("FAIL midrst_beats: got %0d want 5", obs_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL midrst_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (pkt_fwd_count !== 32'd1 || pkt_drop_count !== 32'd0) begin
            failures++;
            $display("FAIL midrst_counts: got %0d/%0d want 1/0", pkt_fwd_count, pkt_drop_count);
        end
    endtask

    initial begin
        test_reset();
        test_single_pkt();
        test_err_pkt();
        test_overflow();
        test_back_to_back();
        test_random();
        test_reset_midpkt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
